// File: rtl/issue_queue_free_list_if.sv
// Dispatch/wakeup-side bundle for the issue queue free list.
// checkError exists only when RSD_IQ_FREE_LIST_CHECK_EN is defined.
interface issue_queue_free_list_if #(
    parameter int ENTRY_NUM     = 16,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RELEASE_WIDTH = 4
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;

    logic [ALLOC_WIDTH-1:0]              allocate;
    logic [ALLOC_WIDTH-1:0][IDX_W-1:0]   allocatedPtr;
    logic [RELEASE_WIDTH-1:0]            releaseEntry;
    logic [RELEASE_WIDTH-1:0][IDX_W-1:0] releasePtr;
    logic                                allocatable;
    logic [CNT_W-1:0]                    freeCount;
`ifdef RSD_IQ_FREE_LIST_CHECK_EN
    logic                                checkError;
`endif

    modport master (
        output allocate,
        output releaseEntry,
        output releasePtr,
        input  allocatedPtr,
        input  allocatable,
        input  freeCount
`ifdef RSD_IQ_FREE_LIST_CHECK_EN
        , input checkError
`endif
    );

    modport slave (
        input  allocate,
        input  releaseEntry,
        input  releasePtr,
        output allocatedPtr,
        output allocatable,
        output freeCount
`ifdef RSD_IQ_FREE_LIST_CHECK_EN
        , output checkError
`endif
    );
endinterface

// File: rtl/issue_queue_free_list.sv
// Issue queue free list: circular FIFO of free entry indices, multi-slot allocate / multi-port release.
// Define RSD_IQ_FREE_LIST_CHECK_EN to add a free bitmap and sticky checkError integrity flag.
module issue_queue_free_list #(
    parameter int ENTRY_NUM     = 16,
    parameter int ALLOC_WIDTH   = 2,
    parameter int RELEASE_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    issue_queue_free_list_if.slave fl_if
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;

    if ((ENTRY_NUM < 4) || ((ENTRY_NUM & (ENTRY_NUM - 1)) != 0)) begin : g_bad_entry_num
        $error("ENTRY_NUM must be a power of two and at least 4");
    end
    if ((ALLOC_WIDTH < 1) || (ALLOC_WIDTH > ENTRY_NUM)) begin : g_bad_alloc_width
        $error("ALLOC_WIDTH must be in 1..ENTRY_NUM");
    end
    if ((RELEASE_WIDTH < 1) || (RELEASE_WIDTH > ENTRY_NUM)) begin : g_bad_release_width
        $error("RELEASE_WIDTH must be in 1..ENTRY_NUM");
    end

    logic [IDX_W-1:0] fifo_q [ENTRY_NUM];
    logic [IDX_W-1:0] fifo_d [ENTRY_NUM];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] free_q, free_d;
    logic [CNT_W-1:0] grant_cnt;
    logic [CNT_W-1:0] rel_cnt;
    logic [CNT_W-1:0] room;

    // Requests are honoured in slot order until the free entries run out.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (fl_if.allocate[i] && (grant_cnt < free_q)) begin
                grant_cnt = grant_cnt + CNT_W'(1);
            end
        end
    end

    // Slots vacated by this cycle's grants count as room, so a full list can still accept
    // as many releases as it grants; anything beyond capacity is dropped and tail holds.
    assign room = CNT_W'(ENTRY_NUM) - free_q + grant_cnt;

    always_comb begin
        for (int e = 0; e < ENTRY_NUM; e++) begin
            fifo_d[e] = fifo_q[e];
        end
        rel_cnt = '0;
        for (int k = 0; k < RELEASE_WIDTH; k++) begin
            if (fl_if.releaseEntry[k] && (rel_cnt < room)) begin
                fifo_d[tail_q + rel_cnt[IDX_W-1:0]] = fl_if.releasePtr[k];
                rel_cnt = rel_cnt + CNT_W'(1);
            end
        end
    end

    assign head_d = head_q + grant_cnt[IDX_W-1:0];
    assign tail_d = tail_q + rel_cnt[IDX_W-1:0];
    assign free_d = free_q - grant_cnt + rel_cnt;

    // Grants read the registered FIFO, so a same-cycle release is never handed out immediately.
    always_comb begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            fl_if.allocatedPtr[i] = fifo_q[head_q + IDX_W'(i)];
        end
    end

    assign fl_if.allocatable = (free_q >= CNT_W'(ALLOC_WIDTH));
    assign fl_if.freeCount   = free_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                fifo_q[e] <= IDX_W'(e);
            end
            head_q <= '0;
            tail_q <= '0;
            free_q <= CNT_W'(ENTRY_NUM);
        end else begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                fifo_q[e] <= fifo_d[e];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            free_q <= free_d;
        end
    end

`ifdef RSD_IQ_FREE_LIST_CHECK_EN
    logic [ENTRY_NUM-1:0] bitmap_q, bitmap_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     chk_g_ord;
    logic [CNT_W-1:0]     chk_r_ord;
    logic [IDX_W-1:0]     chk_g_idx;

    // Bitmap bit set = index currently free. Grants clear, accepted releases set.
    always_comb begin
        bitmap_d  = bitmap_q;
        err_d     = err_q;
        chk_g_ord = '0;
        chk_r_ord = '0;
        chk_g_idx = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (fl_if.allocate[i] && (chk_g_ord < free_q)) begin
                chk_g_idx = fifo_q[head_q + IDX_W'(i)];
                if (!bitmap_q[chk_g_idx]) begin
                    err_d = 1'b1;
                end
                bitmap_d[chk_g_idx] = 1'b0;
                chk_g_ord = chk_g_ord + CNT_W'(1);
            end
        end
        for (int k = 0; k < RELEASE_WIDTH; k++) begin
            if (fl_if.releaseEntry[k]) begin
                if (bitmap_q[fl_if.releasePtr[k]]) begin
                    err_d = 1'b1;
                end
                for (int m = 0; m < k; m++) begin
                    if (fl_if.releaseEntry[m] && (fl_if.releasePtr[m] == fl_if.releasePtr[k])) begin
                        err_d = 1'b1;
                    end
                end
                if (chk_r_ord < room) begin
                    bitmap_d[fl_if.releasePtr[k]] = 1'b1;
                    chk_r_ord = chk_r_ord + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bitmap_q <= '1;
            err_q    <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            err_q    <= err_d;
        end
    end

    assign fl_if.checkError = err_q;
`endif
endmodule

// File: tb/tb_issue_queue_free_list.sv
// Directed bench for issue_queue_free_list (default 16 entries, 2 alloc slots, 4 release ports).
// Checker scenario is compiled in when RSD_IQ_FREE_LIST_CHECK_EN is defined.
module tb_issue_queue_free_list;
    localparam int EN = 16;
    localparam int AW = 2;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec  = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    issue_queue_free_list_if #(.ENTRY_NUM(EN), .ALLOC_WIDTH(AW), .RELEASE_WIDTH(RW)) fl_if ();

    issue_queue_free_list #(.ENTRY_NUM(EN), .ALLOC_WIDTH(AW), .RELEASE_WIDTH(RW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .fl_if (fl_if)
    );

    task automatic drive(input logic [1:0] a, input logic [3:0] r,
                         input logic [3:0] p0, input logic [3:0] p1,
                         input logic [3:0] p2, input logic [3:0] p3);
        fl_if.allocate      = a;
        fl_if.releaseEntry  = r;
        fl_if.releasePtr[0] = p0;
        fl_if.releasePtr[1] = p1;
        fl_if.releasePtr[2] = p2;
        fl_if.releasePtr[3] = p3;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b11, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        tick();
        rst = 1'b0;
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd16) begin errs++; $display("FAIL reset_free: got %0d want 16", fl_if.freeCount); end
        vec++; if (fl_if.allocatable !== 1'b1) begin errs++; $display("FAIL reset_allocatable: got %b want 1", fl_if.allocatable); end
        vec++; if (fl_if.allocatedPtr[0] !== 4'd0) begin errs++; $display("FAIL reset_ptr0: got %0d want 0", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd1) begin errs++; $display("FAIL reset_ptr1: got %0d want 1", fl_if.allocatedPtr[1]); end
`ifdef RSD_IQ_FREE_LIST_CHECK_EN
        vec++; if (fl_if.checkError !== 1'b0) begin errs++; $display("FAIL reset_check_error: got %b want 0", fl_if.checkError); end
`endif
    endtask

    task automatic test_alloc_basic();
        drive(2'b11, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.allocatedPtr[0] !== 4'd0) begin errs++; $display("FAIL alloc_ptr0: got %0d want 0", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd1) begin errs++; $display("FAIL alloc_ptr1: got %0d want 1", fl_if.allocatedPtr[1]); end
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd14) begin errs++; $display("FAIL alloc_free: got %0d want 14", fl_if.freeCount); end
        vec++; if (fl_if.allocatedPtr[0] !== 4'd2) begin errs++; $display("FAIL alloc_next_ptr0: got %0d want 2", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd3) begin errs++; $display("FAIL alloc_next_ptr1: got %0d want 3", fl_if.allocatedPtr[1]); end
    endtask

    task automatic test_drain();
        int exp_free;
        for (int n = 1; n <= 7; n++) begin
            drive(2'b11, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
            tick();
            #1;
            exp_free = 14 - 2 * n;
            vec++; if (fl_if.freeCount !== 5'(exp_free)) begin errs++; $display("FAIL drain_free[%0d]: got %0d want %0d", n, fl_if.freeCount, exp_free); end
            vec++; if (fl_if.allocatable !== (exp_free >= 2)) begin errs++; $display("FAIL drain_allocatable[%0d]: got %b want %b", n, fl_if.allocatable, exp_free >= 2); end
        end
        vec++; if (fl_if.allocatedPtr[0] !== 4'd0) begin errs++; $display("FAIL empty_ptr0: got %0d want 0", fl_if.allocatedPtr[0]); end
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd0) begin errs++; $display("FAIL empty_hold_free: got %0d want 0", fl_if.freeCount); end
        vec++; if (fl_if.allocatable !== 1'b0) begin errs++; $display("FAIL empty_hold_allocatable: got %b want 0", fl_if.allocatable); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd1) begin errs++; $display("FAIL empty_hold_ptr1: got %0d want 1", fl_if.allocatedPtr[1]); end
    endtask

    task automatic test_release_empty();
        drive(2'b00, 4'b1010, 4'd0, 4'd5, 4'd0, 4'd9);
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd2) begin errs++; $display("FAIL rel_empty_free: got %0d want 2", fl_if.freeCount); end
        vec++; if (fl_if.allocatable !== 1'b1) begin errs++; $display("FAIL rel_empty_allocatable: got %b want 1", fl_if.allocatable); end
        vec++; if (fl_if.allocatedPtr[0] !== 4'd5) begin errs++; $display("FAIL rel_empty_first: got %0d want 5", fl_if.allocatedPtr[0]); end
        drive(2'b01, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.allocatedPtr[0] !== 4'd9) begin errs++; $display("FAIL rel_empty_second: got %0d want 9", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.freeCount !== 5'd1) begin errs++; $display("FAIL rel_empty_free1: got %0d want 1", fl_if.freeCount); end
        drive(2'b01, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd0) begin errs++; $display("FAIL rel_empty_free0: got %0d want 0", fl_if.freeCount); end
    endtask

    // head=2, tail=2 on entry; 13 releases put tail at 15, then 3 more wrap into slots 15, 0, 1.
    task automatic test_wrap();
        drive(2'b00, 4'b1111, 4'd0, 4'd1, 4'd2, 4'd3);
        tick();
        drive(2'b00, 4'b1111, 4'd4, 4'd5, 4'd6, 4'd7);
        tick();
        drive(2'b00, 4'b1111, 4'd8, 4'd9, 4'd10, 4'd11);
        tick();
        drive(2'b00, 4'b0001, 4'd12, 4'd0, 4'd0, 4'd0);
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd13) begin errs++; $display("FAIL wrap_free13: got %0d want 13", fl_if.freeCount); end
        drive(2'b00, 4'b0111, 4'd13, 4'd14, 4'd15, 4'd0);
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd16) begin errs++; $display("FAIL wrap_free16: got %0d want 16", fl_if.freeCount); end
        for (int n = 0; n < 6; n++) begin
            drive(2'b11, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
            #1;
            vec++; if (fl_if.allocatedPtr[0] !== 4'(2 * n)) begin errs++; $display("FAIL wrap_ptr0[%0d]: got %0d want %0d", n, fl_if.allocatedPtr[0], 2 * n); end
            vec++; if (fl_if.allocatedPtr[1] !== 4'(2 * n + 1)) begin errs++; $display("FAIL wrap_ptr1[%0d]: got %0d want %0d", n, fl_if.allocatedPtr[1], 2 * n + 1); end
            tick();
        end
        drive(2'b11, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.allocatedPtr[0] !== 4'd12) begin errs++; $display("FAIL wrap_slot14: got %0d want 12", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd13) begin errs++; $display("FAIL wrap_slot15: got %0d want 13", fl_if.allocatedPtr[1]); end
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.allocatedPtr[0] !== 4'd14) begin errs++; $display("FAIL wrap_slot0: got %0d want 14", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd15) begin errs++; $display("FAIL wrap_slot1: got %0d want 15", fl_if.allocatedPtr[1]); end
        vec++; if (fl_if.freeCount !== 5'd2) begin errs++; $display("FAIL wrap_free2: got %0d want 2", fl_if.freeCount); end
    endtask

    // freeCount=2, head=0, tail=2 on entry.
    task automatic test_alloc_release_same();
        drive(2'b11, 4'b0001, 4'd7, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.allocatedPtr[0] !== 4'd14) begin errs++; $display("FAIL same_ptr0: got %0d want 14", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd15) begin errs++; $display("FAIL same_ptr1: got %0d want 15", fl_if.allocatedPtr[1]); end
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd1) begin errs++; $display("FAIL same_free: got %0d want 1", fl_if.freeCount); end
        vec++; if (fl_if.allocatable !== 1'b0) begin errs++; $display("FAIL same_allocatable: got %b want 0", fl_if.allocatable); end
        vec++; if (fl_if.allocatedPtr[0] !== 4'd7) begin errs++; $display("FAIL same_next_ptr0: got %0d want 7", fl_if.allocatedPtr[0]); end
        drive(2'b11, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd0) begin errs++; $display("FAIL partial_grant_free: got %0d want 0", fl_if.freeCount); end
    endtask

    // Mid-operation reset, then a release into the full list (also a double release of a free index).
    task automatic test_full_saturate();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(2'b00, 4'b0001, 4'd3, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd16) begin errs++; $display("FAIL midreset_free: got %0d want 16", fl_if.freeCount); end
`ifdef RSD_IQ_FREE_LIST_CHECK_EN
        vec++; if (fl_if.checkError !== 1'b0) begin errs++; $display("FAIL chk_before: got %b want 0", fl_if.checkError); end
`endif
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd16) begin errs++; $display("FAIL full_sat_free: got %0d want 16", fl_if.freeCount); end
        vec++; if (fl_if.allocatedPtr[0] !== 4'd0) begin errs++; $display("FAIL full_sat_ptr0: got %0d want 0", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd1) begin errs++; $display("FAIL full_sat_ptr1: got %0d want 1", fl_if.allocatedPtr[1]); end
`ifdef RSD_IQ_FREE_LIST_CHECK_EN
        vec++; if (fl_if.checkError !== 1'b1) begin errs++; $display("FAIL chk_set: got %b want 1", fl_if.checkError); end
`endif
        drive(2'b11, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        #1;
        vec++; if (fl_if.freeCount !== 5'd14) begin errs++; $display("FAIL full_after_free: got %0d want 14", fl_if.freeCount); end
        vec++; if (fl_if.allocatedPtr[0] !== 4'd2) begin errs++; $display("FAIL full_after_ptr0: got %0d want 2", fl_if.allocatedPtr[0]); end
        vec++; if (fl_if.allocatedPtr[1] !== 4'd3) begin errs++; $display("FAIL full_after_ptr1: got %0d want 3", fl_if.allocatedPtr[1]); end
`ifdef RSD_IQ_FREE_LIST_CHECK_EN
        tick();
        tick();
        #1;
        vec++; if (fl_if.checkError !== 1'b1) begin errs++; $display("FAIL chk_sticky: got %b want 1", fl_if.checkError); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vec++; if (fl_if.checkError !== 1'b0) begin errs++; $display("FAIL chk_cleared: got %b want 0", fl_if.checkError); end
`endif
    endtask

    initial begin
        drive(2'b00, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_alloc_basic();
        test_drain();
        test_release_empty();
        test_wrap();
        test_alloc_release_same();
        test_full_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/issue_queue_free_list.md
ISSUE_QUEUE_FREE_LIST -- requirements
Module: issue_queue_free_list

Interface
REQ-001 The block SHALL take parameter ENTRY_NUM, default 16, issue queue entries managed (power of two, >= 4).
REQ-002 The block SHALL take parameter ALLOC_WIDTH, default 2, entries allocatable per cycle (dispatch width).
REQ-003 The block SHALL take parameter RELEASE_WIDTH, default 4, entries releasable per cycle (int+complex+mem issue width).
REQ-004 The block SHALL have port clk, input, 1, clock; the design has one clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port allocate, input, ALLOC_WIDTH, per-slot allocation request from dispatch.
REQ-007 The block SHALL have port allocatedPtr, output, ALLOC_WIDTH x clog2(ENTRY_NUM), entry index granted to each slot.
REQ-008 The block SHALL have port releaseEntry, input, RELEASE_WIDTH, per-port release strobe from the wakeup pipeline register.
REQ-009 The block SHALL have port releasePtr, input, RELEASE_WIDTH x clog2(ENTRY_NUM), entry index released on each port.
REQ-010 The block SHALL have port allocatable, output, 1, high when freeCount >= ALLOC_WIDTH.
REQ-011 The block SHALL have port freeCount, output, clog2(ENTRY_NUM)+1, free entries held.

Function
REQ-012 The block SHALL hold free indices in a circular FIFO of ENTRY_NUM slots, with headPtr, tailPtr, and freeCount registers.
REQ-013 The block SHALL drive allocatedPtr[i] combinationally as fifo[(headPtr+i) mod ENTRY_NUM], with zero-cycle latency.
REQ-014 The block SHALL advance headPtr by the popcount of allocate, honouring only the first freeCount requests in slot order.
REQ-015 The block SHALL compact valid releases in port order, write port k's index at fifo[(tailPtr+ordinal_k) mod ENTRY_NUM], and advance tailPtr by the popcount of releaseEntry.
REQ-016 The block SHALL update freeCount as freeCount - granted + released, evaluated in the same cycle.
REQ-017 On simultaneous allocate and release, allocatedPtr SHALL use pre-update FIFO contents, so a released index becomes allocatable no earlier than the next cycle.
REQ-018 The block SHALL wrap pointer arithmetic modulo ENTRY_NUM with no bubble at the wrap boundary.
REQ-019 When the FIFO is empty (freeCount=0), allocatable SHALL be 0, headPtr SHALL hold, and releases SHALL still be accepted.
REQ-020 When the FIFO is full (freeCount=ENTRY_NUM), further releases are a protocol violation; freeCount SHALL saturate at ENTRY_NUM and tailPtr SHALL hold.

Reset
REQ-021 When rst is high, the block SHALL set fifo[i]=i, headPtr=0, tailPtr=0, freeCount=ENTRY_NUM, allocatable=1.
REQ-022 Reset SHALL override any allocate or release in the same cycle, and SHALL discard mid-operation state.

Configuration
REQ-023 With RSD_IQ_FREE_LIST_CHECK_EN defined, the block SHALL maintain an ENTRY_NUM-bit free bitmap and an output checkError (1 bit, reset 0).
REQ-024 With the macro defined, checkError SHALL be set sticky on any of: double release of an already-free index, two ports releasing the same index in one cycle, or allocation of a non-free index.
REQ-025 Without RSD_IQ_FREE_LIST_CHECK_EN, the bitmap and checkError port SHALL be absent and the functional behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover reset then allocate=2'b11 -> allocatedPtr={0,1}; next cycle freeCount=14, and allocatedPtr={2,3}.
REQ-027 The bench SHALL cover eight allocate=2'b11 cycles from reset -> freeCount=0, allocatable=0; a further request leaves headPtr unchanged.
REQ-028 The bench SHALL cover a drained FIFO with releaseEntry=4'b1010 and releasePtr[1]=5, releasePtr[3]=9 -> the next two allocations are 5 then 9, and freeCount goes 0->2.
REQ-029 The bench SHALL cover tailPtr=15 with three releases -> writes at slots 15, 0, 1; those indices are later allocated in port order.
REQ-030 The bench SHALL cover freeCount=2 with allocate=2'b11 and one release of 7 in the same cycle -> grants use old head entries, 7 is not granted, and the next freeCount is 1.
REQ-031 The bench SHALL cover, with RSD_IQ_FREE_LIST_CHECK_EN, releasing index 3 while it is free -> checkError=1 next cycle, held until rst.
